// File: rtl/demux16_pkg.sv
// Shared types and constants for the 1-to-16 dispatch demultiplexer.
//   NCH       : number of destination channels
//   SEL_W     : width of the binary channel index
//   CNT_W     : width of the optional stall counter
//   STALL_MAX : saturation value of the stall counter
package demux16_pkg;

    localparam int unsigned NCH   = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [NCH-1:0]   onehot_t;

    localparam logic [CNT_W-1:0] STALL_MAX = 8'd255;

endpackage

// File: rtl/demux16_dispatch_if.sv
// Producer/consumer bundle for demux16_dispatch.
//   in_valid/in_ready/in_sel/in_data : producer handshake and payload
//   out_data/out_valid/out_ack       : per-channel holding registers and handshake
//   sel_onehot/busy                  : registered select vector and activity flag
//   stall_cnt                        : present only with DEMUX16_STALL_CNT_EN
// Modports: master = bench/producer/consumer side, slave = dispatch block.
interface demux16_dispatch_if #(
    parameter int unsigned WIDTH = 16
);
    import demux16_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    sel_t                 in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [NCH*WIDTH-1:0] out_data;
    onehot_t              out_valid;
    onehot_t              out_ack;
    onehot_t              sel_onehot;
    logic                 busy;
`ifdef DEMUX16_STALL_CNT_EN
    logic [CNT_W-1:0]     stall_cnt;
`endif

    modport master (
        output in_valid, in_sel, in_data, out_ack,
        input  in_ready, out_data, out_valid, sel_onehot, busy
`ifdef DEMUX16_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ack,
        output in_ready, out_data, out_valid, sel_onehot, busy
`ifdef DEMUX16_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/demux16_dispatch_onehot_dec4.sv
// onehot_dec4: combinational 4-to-16 binary to one-hot decoder.
//   i_sel    : binary channel index
//   o_onehot : exactly one bit set at position i_sel
module onehot_dec4
    import demux16_pkg::*;
(
    input  sel_t    i_sel,
    output onehot_t o_onehot
);

    always_comb begin
        o_onehot = onehot_t'(1) << i_sel;
    end

endmodule

// File: rtl/demux16_dispatch.sv
// demux16_dispatch: registered 1-to-16 demultiplexer with per-channel holding
// registers and valid/ack handshake; also emits the registered one-hot select.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : demux16_dispatch_if.slave (producer handshake, channel outputs)
// Optional: define DEMUX16_STALL_CNT_EN to add the saturating stall counter.
module demux16_dispatch
    import demux16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    demux16_dispatch_if.slave bus
);

    logic [NCH-1:0][WIDTH-1:0] r_data;
    onehot_t                   r_valid;
    onehot_t                   r_onehot;
    onehot_t                   w_dec;
    onehot_t                   w_we;
    logic                      w_ready;
    logic                      w_acc;

    onehot_dec4 u_dec (
        .i_sel    (bus.in_sel),
        .o_onehot (w_dec)
    );

    // A full channel acked this cycle frees its slot for a same-cycle refill.
    assign w_ready = ~r_valid[bus.in_sel] | bus.out_ack[bus.in_sel];
    assign w_acc   = bus.in_valid & w_ready;
    assign w_we    = w_acc ? w_dec : onehot_t'(0);

    // Holding registers: a new write wins over an ack on the same channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= onehot_t'(0);
            r_data   <= '0;
            r_onehot <= onehot_t'(1);
        end else begin
            r_valid <= (r_valid & ~bus.out_ack) | w_we;
            for (int k = 0; k < NCH; k++) begin
                if (w_we[k]) begin
                    r_data[k] <= bus.in_data;
                end
            end
            if (w_acc) begin
                r_onehot <= w_dec;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_data   = r_data;
    assign bus.out_valid  = r_valid;
    assign bus.sel_onehot = r_onehot;
    assign bus.busy       = |r_valid;

`ifdef DEMUX16_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall;

    // Counts refused requests, saturating instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall <= CNT_W'(0);
        end else if (bus.in_valid && !w_ready && (r_stall != STALL_MAX)) begin
            r_stall <= r_stall + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_demux16_dispatch.sv
// Self-checking bench for demux16_dispatch: directed scenarios followed by
// randomized traffic, compared against a channel-array reference model.
module tb_demux16_dispatch;
    import demux16_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DW    = NCH * WIDTH;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    demux16_dispatch_if #(.WIDTH(WIDTH)) bus ();

    demux16_dispatch #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: one entry per destination channel.
    logic             m_full [NCH];
    logic [WIDTH-1:0] m_word [NCH];
    int               m_last;
    int               m_stall;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_full[k] = 1'b0;
            m_word[k] = '0;
        end
        m_last  = 0;
        m_stall = 0;
    endtask

    function automatic logic [255:0] exp_valid();
        logic [255:0] v = '0;
        for (int k = 0; k < NCH; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [255:0] exp_data();
        logic [255:0] v = '0;
        for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = m_word[k];
        return v;
    endfunction

    function automatic logic exp_busy();
        logic b = 1'b0;
        for (int k = 0; k < NCH; k++) b = b | m_full[k];
        return b;
    endfunction

    task automatic check_state(input string tag);
        logic [255:0] oh;
        oh = '0;
        oh[m_last] = 1'b1;
        check_eq({tag, "_out_valid"},  256'(bus.out_valid),  exp_valid());
        check_eq({tag, "_out_data"},   256'(bus.out_data),   exp_data());
        check_eq({tag, "_sel_onehot"}, 256'(bus.sel_onehot), oh);
        check_eq({tag, "_busy"},       256'(bus.busy),       256'(exp_busy()));
`ifdef DEMUX16_STALL_CNT_EN
        check_eq({tag, "_stall_cnt"},  256'(bus.stall_cnt),  256'(m_stall));
`endif
    endtask

    // Drive one request for one clock, checking ready before and state after the edge.
    task automatic cycle(input string tag, input logic v, input int s,
                         input logic [WIDTH-1:0] d, input logic [NCH-1:0] a);
        logic rdy;
        bus.in_valid = v;
        bus.in_sel   = SEL_W'(s);
        bus.in_data  = d;
        bus.out_ack  = a;
        #1;
        rdy = !m_full[s] || a[s];
        check_eq({tag, "_in_ready"}, 256'(bus.in_ready), 256'(rdy));
        @(posedge clk);
        for (int k = 0; k < NCH; k++) begin
            if (v && rdy && k == s) begin
                m_full[k] = 1'b1;
                m_word[k] = d;
            end else if (a[k]) begin
                m_full[k] = 1'b0;
            end
        end
        if (v && rdy) m_last = s;
        if (v && !rdy && m_stall < 255) m_stall++;
        #1;
        check_state(tag);
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sel   = '0;
        bus.in_data  = '0;
        bus.out_ack  = '0;
        model_reset();
        #12;
        check_state("rst");
        check_eq("rst_in_ready", 256'(bus.in_ready), 256'(1));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // First accept and its latency.
        cycle("first", 1'b1, 3, 16'h5750, 16'h0000);
        check_eq("first_ch3", 256'(bus.out_data[3*WIDTH +: WIDTH]), 256'(16'h5750));

        // Back-pressure on a full channel without ack.
        for (int i = 0; i < 3; i++) cycle("bp", 1'b1, 3, 16'h1234, 16'h0000);
        check_eq("bp_ch3", 256'(bus.out_data[3*WIDTH +: WIDTH]), 256'(16'h5750));

        // Pass-through refill: ack and accept on the same channel.
        cycle("refill", 1'b1, 3, 16'hABAB, 16'h0008);
        check_eq("refill_ch3", 256'(bus.out_data[3*WIDTH +: WIDTH]), 256'(16'hABAB));

        // Ack on ch3 while accepting ch15.
        cycle("conc", 1'b1, 15, 16'hFFFF, 16'h0008);
        check_eq("conc_valid", 256'(bus.out_valid), 256'(16'h8000));
        check_eq("conc_onehot", 256'(bus.sel_onehot), 256'(16'h8000));

`ifdef DEMUX16_STALL_CNT_EN
        // Long stall on full ch15 drives the counter to saturation.
        for (int i = 0; i < 300; i++) cycle("sat", 1'b1, 15, 16'h0BAD, 16'h0000);
        check_eq("sat_final", 256'(bus.stall_cnt), 256'(255));
`endif

        // Mid-operation reset with ch0, ch7 and ch15 full.
        cycle("fill0", 1'b1, 0, 16'h0101, 16'h0000);
        cycle("fill7", 1'b1, 7, 16'h0707, 16'h0000);
        check_eq("fill_valid", 256'(bus.out_valid), 256'(16'h8081));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_state("midrst");
        check_eq("midrst_in_ready", 256'(bus.in_ready), 256'(1));
        #1;
        reset = 1'b0;
        cycle("post_rst", 1'b1, 9, 16'h0909, 16'h0000);

        // Randomized traffic with sparse acks.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                  WIDTH'($urandom), NCH'($urandom & $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
